// File: rtl/fmul_seq.sv
// Iterative IEEE-754 single-precision multiplier: shift-add mantissa product, R bits per cycle,
// then normalise and round-to-nearest-even. Valid/ready on both issue and writeback sides.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready=1
// MUL   | accumulating R partial products per cycle for N cycles
// NORM  | normalise product, denormalise into subnormal range if needed
// ROUND | round to nearest even, pack result, detect overflow
// DONE  | result held on y/ovf until the consumer takes it
module fmul_seq #(
    parameter int R = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] y,
    output logic        ovf,
    output logic        out_valid,
    input  logic        out_ready
);
    localparam int N = 24 / R;

    typedef enum logic [2:0] {IDLE, MUL, NORM, ROUND, DONE} state_t;

    state_t             state;
    logic [4:0]         cnt;
    logic [47:0]        mcand;
    logic [23:0]        mb_sh;
    logic [47:0]        acc;
    logic signed [9:0]  et;
    logic               sgn;
    logic               sticky;

    logic        s1, s2;
    logic [7:0]  e1, e2;
    logic [22:0] f1, f2;
    logic        nan1, nan2, inf1, inf2, zero1, zero2, special;
    logic [31:0] y_sp;
    logic [7:0]  ea1, ea2;
    logic signed [9:0] et_init;

    assign {s1, e1, f1} = x1;
    assign {s2, e2, f2} = x2;
    assign nan1  = (e1 == 8'hff) && (f1 != '0);
    assign nan2  = (e2 == 8'hff) && (f2 != '0);
    assign inf1  = (e1 == 8'hff) && (f1 == '0);
    assign inf2  = (e2 == 8'hff) && (f2 == '0);
    assign zero1 = (e1 == 8'h00) && (f1 == '0);
    assign zero2 = (e2 == 8'h00) && (f2 == '0);
    assign special = nan1 | nan2 | inf1 | inf2 | zero1 | zero2;
    assign ea1 = (e1 == 8'h00) ? 8'd1 : e1;
    assign ea2 = (e2 == 8'h00) ? 8'd1 : e2;
    assign et_init = $signed({2'b00, ea1}) + $signed({2'b00, ea2}) - 10'sd127;

    always_comb begin
        if (nan1)                                    y_sp = {s1, 8'hff, 1'b1, f1[21:0]};
        else if (nan2)                               y_sp = {s2, 8'hff, 1'b1, f2[21:0]};
        else if ((zero1 && inf2) || (inf1 && zero2)) y_sp = 32'hffc0_0000;
        else if (inf1 || inf2)                       y_sp = {s1 ^ s2, 8'hff, 23'd0};
        else                                         y_sp = {s1 ^ s2, 31'd0};
    end

    logic [47:0] pp;
    always_comb begin
        pp = '0;
        for (int i = 0; i < R; i++)
            if (mb_sh[i]) pp = pp + (mcand << i);
    end

    // Normalisation: the hidden bit ends up at p[46]; bits shifted out to the right feed sticky.
    logic [47:0]       p_a, p_n, mask;
    logic signed [9:0] et_a, et_n, lim;
    logic [9:0]        sh;
    logic [5:0]        lz, lz_b;
    logic              st_n;
    always_comb begin
        lz = 6'd47;
        for (int i = 0; i < 47; i++)
            if (acc[i]) lz = 6'(46 - i);
        lim = et - 10'sd1;
        if (lim < 10'sd0)                    lz_b = '0;
        else if ($signed({4'b0, lz}) > lim)  lz_b = lim[5:0];
        else                                 lz_b = lz;
        st_n = 1'b0;
        mask = '0;
        sh   = '0;
        if (acc[47]) begin
            p_a  = acc >> 1;
            st_n = acc[0];
            et_a = et + 10'sd1;
        end else begin
            p_a  = acc << lz_b;
            et_a = et - $signed({4'b0, lz_b});
        end
        p_n  = p_a;
        et_n = et_a;
        if (et_a < 10'sd1) begin
            sh = unsigned'(10'sd1 - et_a);
            if (sh >= 10'd48) begin
                st_n = st_n | (|p_a);
                p_n  = '0;
            end else begin
                mask = (48'd1 << sh) - 48'd1;
                st_n = st_n | (|(p_a & mask));
                p_n  = p_a >> sh;
            end
            et_n = '0;
        end
    end

    logic [23:0]       m, m_f;
    logic [24:0]       mr;
    logic              up;
    logic signed [9:0] et_r;
    logic [31:0]       y_r;
    logic              ovf_r;
    always_comb begin
        m    = acc[46:23];
        up   = acc[22] & (sticky | (|acc[21:0]) | m[0]);
        mr   = {1'b0, m} + {24'd0, up};
        et_r = et;
        if (mr[24]) begin
            m_f  = 24'h80_0000;
            et_r = et + 10'sd1;
        end else begin
            m_f = mr[23:0];
            if (!m[23] && mr[23]) et_r = 10'sd1;
        end
        if (et_r >= 10'sd255) begin
            y_r   = {sgn, 8'hff, 23'd0};
            ovf_r = 1'b1;
        end else begin
            y_r   = {sgn, (m_f[23] ? et_r[7:0] : 8'd0), m_f[22:0]};
            ovf_r = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            mcand     <= '0;
            mb_sh     <= '0;
            acc       <= '0;
            et        <= '0;
            sgn       <= 1'b0;
            sticky    <= 1'b0;
            y         <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    in_ready <= 1'b0;
                    sgn      <= s1 ^ s2;
                    if (special) begin
                        y     <= y_sp;
                        ovf   <= 1'b0;
                        state <= DONE;
                    end else begin
                        mcand  <= {24'd0, (e1 != 8'h00), f1};
                        mb_sh  <= {(e2 != 8'h00), f2};
                        acc    <= '0;
                        et     <= et_init;
                        sticky <= 1'b0;
                        cnt    <= '0;
                        state  <= MUL;
                    end
                end
                MUL: begin
                    acc   <= acc + pp;
                    mcand <= mcand << R;
                    mb_sh <= mb_sh >> R;
                    cnt   <= cnt + 5'd1;
                    if (cnt == 5'(N - 1)) state <= NORM;
                end
                NORM: begin
                    acc    <= p_n;
                    et     <= et_n;
                    sticky <= st_n;
                    state  <= ROUND;
                end
                ROUND: begin
                    y         <= y_r;
                    ovf       <= ovf_r;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    // Special results arrive here with out_valid still low; raise it one cycle later.
                    if (!out_valid) out_valid <= 1'b1;
                    else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fmul_seq.sv
// Bench for fmul_seq: R=1 and R=4 instances, directed vectors plus random operands
// checked against an exact-arithmetic rounding model.
module tb_fmul_seq;
    localparam int RV [2] = '{1, 4};

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] x1_s [2];
    logic [31:0] x2_s [2];
    logic        in_valid_s [2];
    logic        in_ready_s [2];
    logic [31:0] y_s [2];
    logic        ovf_s [2];
    logic        out_valid_s [2];
    logic        out_ready_s [2];

    int ncmp = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    fmul_seq #(.R(1)) dut0 (
        .clk(clk), .rstn(rstn), .x1(x1_s[0]), .x2(x2_s[0]), .in_valid(in_valid_s[0]),
        .in_ready(in_ready_s[0]), .y(y_s[0]), .ovf(ovf_s[0]), .out_valid(out_valid_s[0]),
        .out_ready(out_ready_s[0]));

    fmul_seq #(.R(4)) dut1 (
        .clk(clk), .rstn(rstn), .x1(x1_s[1]), .x2(x2_s[1]), .in_valid(in_valid_s[1]),
        .in_ready(in_ready_s[1]), .y(y_s[1]), .ovf(ovf_s[1]), .out_valid(out_valid_s[1]),
        .out_ready(out_ready_s[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_special(input logic [31:0] a);
        return (a[30:23] == 8'hff) || (a[30:0] == 31'd0);
    endfunction

    // Exact product value = P * 2^E, rounded onto the single-precision grid (lsb weight >= 2^-149).
    function automatic logic [32:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic sa, sb, s;
        int ea, eb, k, q, drop, E, be;
        longint unsigned ma, mb, P, kept, rem, half, one;
        bit na, nb, ia, ib, za, zb;
        sa = a[31]; sb = b[31]; s = sa ^ sb;
        na = (a[30:23] == 8'hff) && (a[22:0] != 0);
        nb = (b[30:23] == 8'hff) && (b[22:0] != 0);
        ia = (a[30:23] == 8'hff) && (a[22:0] == 0);
        ib = (b[30:23] == 8'hff) && (b[22:0] == 0);
        za = (a[30:0] == 0);
        zb = (b[30:0] == 0);
        if (na) return {1'b0, sa, 8'hff, 1'b1, a[21:0]};
        if (nb) return {1'b0, sb, 8'hff, 1'b1, b[21:0]};
        if ((za && ib) || (ia && zb)) return {1'b0, 32'hffc0_0000};
        if (ia || ib) return {1'b0, s, 8'hff, 23'd0};
        if (za || zb) return {1'b0, s, 31'd0};
        ea = (a[30:23] == 0) ? 1 : int'(a[30:23]);
        eb = (b[30:23] == 0) ? 1 : int'(b[30:23]);
        ma = {40'd0, (a[30:23] != 0), a[22:0]};
        mb = {40'd0, (b[30:23] != 0), b[22:0]};
        P = ma * mb;
        E = ea + eb - 300;
        k = 0;
        for (int i = 0; i < 48; i++) if (P[i]) k = i;
        q = k + E - 23;
        if (q < -149) q = -149;
        drop = q - E;
        one = 1;
        if (drop <= 0) kept = P << (-drop);
        else if (drop >= 50) kept = 0;
        else begin
            kept = P >> drop;
            rem  = P & ((one << drop) - 1);
            half = one << (drop - 1);
            if (rem > half || (rem == half && kept[0])) kept = kept + 1;
        end
        if (kept == (one << 24)) begin
            kept = one << 23;
            q = q + 1;
        end
        if (kept < (one << 23)) return {1'b0, s, 8'd0, kept[22:0]};
        be = q + 150;
        if (be >= 255) return {1'b1, s, 8'hff, 23'd0};
        return {1'b0, s, be[7:0], kept[22:0]};
    endfunction

    task automatic wait_valid(input int d, output int lat);
        lat = 0;
        while (!out_valid_s[d] && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_op(input int d, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ey, input logic eo, input string tag);
        int lat, exp_lat;
        exp_lat = is_special(a) || is_special(b) ? 1 : 24 / RV[d] + 2;
        @(negedge clk);
        chk({tag, "/in_ready"}, 32'(in_ready_s[d]), 32'd1);
        x1_s[d] = a; x2_s[d] = b; in_valid_s[d] = 1'b1;
        @(posedge clk); #1;
        in_valid_s[d] = 1'b0;
        wait_valid(d, lat);
        chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "/y"}, y_s[d], ey);
        chk({tag, "/ovf"}, 32'(ovf_s[d]), 32'(eo));
        @(negedge clk); out_ready_s[d] = 1'b1;
        @(posedge clk); #1; out_ready_s[d] = 1'b0;
        chk({tag, "/out_valid_drop"}, 32'(out_valid_s[d]), 32'd0);
    endtask

    function automatic logic [31:0] rnd_op();
        logic [7:0] e;
        logic [22:0] f;
        int c;
        c = $urandom_range(0, 9);
        f = 23'($urandom);
        if ($urandom_range(0, 5) == 0) f = '0;
        case (c)
            0: e = 8'd0;
            1: e = 8'hff;
            2: e = 8'($urandom_range(200, 254));
            3: e = 8'($urandom_range(1, 30));
            default: e = 8'($urandom_range(100, 154));
        endcase
        return {1'($urandom), e, f};
    endfunction

    initial begin
        logic [31:0] a, b;
        logic [32:0] r;
        int lat, seen;
        for (int d = 0; d < 2; d++) begin
            x1_s[d] = '0; x2_s[d] = '0; in_valid_s[d] = 1'b0; out_ready_s[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset/in_ready", 32'(in_ready_s[0]), 32'd1);
        chk("reset/out_valid", 32'(out_valid_s[0]), 32'd0);
        chk("reset/y", y_s[0], 32'd0);
        chk("reset/ovf", 32'(ovf_s[0]), 32'd0);
        chk("reset/in_ready_r4", 32'(in_ready_s[1]), 32'd1);
        @(negedge clk); rstn = 1'b1;

        do_op(0, 32'h3fc0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, "t1");
        do_op(0, 32'h0000_0000, 32'h7f80_0000, 32'hffc0_0000, 1'b0, "zero_x_inf");
        do_op(0, 32'h7fc1_2345, 32'h3f80_0000, 32'h7fc1_2345, 1'b0, "nan1");
        do_op(0, 32'h3f80_0000, 32'hff81_0001, 32'hffc1_0001, 1'b0, "nan2_quiet");
        do_op(0, 32'hff80_0000, 32'h4000_0000, 32'hff80_0000, 1'b0, "inf");
        do_op(0, 32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 1'b0, "neg_zero");
        do_op(0, 32'h7f7f_ffff, 32'h4000_0000, 32'h7f80_0000, 1'b1, "ovf");
        do_op(0, 32'h0080_0000, 32'h3f00_0000, 32'h0040_0000, 1'b0, "subnormal");
        do_op(0, 32'h3f80_0001, 32'h3fc0_0000, 32'h3fc0_0002, 1'b0, "tie_even");
        do_op(0, 32'h3f80_0001, 32'h3f80_0001, 32'h3f80_0002, 1'b0, "rnd_up");
        do_op(0, 32'h0000_0001, 32'h3f00_0000, 32'h0000_0000, 1'b0, "tie_zero");

        // Back-pressure: result must stay put and a waiting operand must not be taken.
        @(negedge clk);
        x1_s[0] = 32'h3fc0_0000; x2_s[0] = 32'h4000_0000; in_valid_s[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_s[0] = 1'b0;
        wait_valid(0, lat);
        chk("bp/latency", 32'(lat), 32'd26);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            x1_s[0] = 32'h4000_0000; x2_s[0] = 32'h4040_0000; in_valid_s[0] = 1'b1;
            @(posedge clk); #1;
            chk("bp/y_stable", y_s[0], 32'h4040_0000);
            chk("bp/out_valid", 32'(out_valid_s[0]), 32'd1);
            chk("bp/in_ready", 32'(in_ready_s[0]), 32'd0);
        end
        @(negedge clk); out_ready_s[0] = 1'b1;
        @(posedge clk); #1; out_ready_s[0] = 1'b0;
        chk("bp/handshake_ov", 32'(out_valid_s[0]), 32'd0);
        chk("bp/handshake_ir", 32'(in_ready_s[0]), 32'd1);
        @(posedge clk); #1; in_valid_s[0] = 1'b0;
        chk("bp/accepted", 32'(in_ready_s[0]), 32'd0);
        wait_valid(0, lat);
        chk("bp/next_latency", 32'(lat), 32'd26);
        chk("bp/next_y", y_s[0], 32'h40c0_0000);
        @(negedge clk); out_ready_s[0] = 1'b1;
        @(posedge clk); #1; out_ready_s[0] = 1'b0;

        // Reset during MUL cycle 10.
        @(negedge clk);
        x1_s[0] = 32'h3fc0_0000; x2_s[0] = 32'h4000_0000; in_valid_s[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_s[0] = 1'b0;
        repeat (10) @(posedge clk);
        #1; rstn = 1'b0;
        #1;
        chk("rst/out_valid", 32'(out_valid_s[0]), 32'd0);
        chk("rst/in_ready", 32'(in_ready_s[0]), 32'd1);
        @(negedge clk); rstn = 1'b1;
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid_s[0]) seen++;
        end
        chk("rst/no_output", 32'(seen), 32'd0);
        do_op(0, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 1'b0, "after_rst");

        do_op(1, 32'h3fc0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, "r4/t1");
        do_op(1, 32'h3f80_0001, 32'h3fc0_0000, 32'h3fc0_0002, 1'b0, "r4/tie_even");
        do_op(1, 32'h3f80_0001, 32'h3f80_0001, 32'h3f80_0002, 1'b0, "r4/rnd_up");
        do_op(1, 32'h0000_0001, 32'h3f00_0000, 32'h0000_0000, 1'b0, "r4/tie_zero");

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 40; i++) begin
                a = rnd_op();
                b = rnd_op();
                r = ref_mul(a, b);
                do_op(d, a, b, r[31:0], r[32], $sformatf("rnd%0d_%0d", d, i));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
